alu_engine: RTL
===============

Name: alu_engine

Overview:
- Parametrised, handshake-driven successor to the bus-attached ALU controller.
- Accepts an opcode plus two WIDTH-bit operands through a valid/ready handshake.
- Single-cycle ops: add, sub, mul, logic. Divide/modulus use a built-in iterative restoring divider, so no external divider core is needed.
- Holds the result and a sticky-free status flag word until the consumer accepts them. Sits between the CPU control sequencer and the datapath bus drivers.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- OPW, 4, opcode field width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  request strobe; opcode/operands are valid.
- op_ready  out  1  engine can accept a request this cycle.
- opcode  in  OPW  operation select.
- opa  in  WIDTH  operand A.
- opb  in  WIDTH  operand B.
- res_valid  out  1  result/flags are valid.
- res_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result.
- result_hi  out  WIDTH  MUL upper half; DIV/MOD remainder/quotient companion; else 0.
- flags  out  5  {ILL, DZ, V, N, Z, C} minus V -> bits [4:0] = {ILL, DZ, N, Z, C}.
- busy  out  1  divider iteration in progress.

Behaviour:
- Reset: state IDLE; op_ready=1; res_valid=0; result, result_hi, flags=0; busy=0. Reset has priority over all other events, including mid-division: the iteration is aborted and the partial result is discarded.
- Accept: a transfer occurs when op_valid && op_ready, sampled at the clock edge. Operands are registered at accept; later changes are ignored.
- op_ready = (state==IDLE) && !res_valid. There is no combinational path from res_ready to op_ready.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR. Codes 8..15 are illegal.
- Single-cycle ops (ADD, SUB, MUL, logic, illegal): res_valid rises on the edge after accept (latency 1).
- ADD: result = (A+B) mod 2^WIDTH; C = carry out.
- SUB: result = A-B; C = borrow (A<B unsigned).
- MUL: unsigned 2*WIDTH product; result = low half, result_hi = high half; C = (high half != 0).
- Logic ops: C=0.
- Illegal opcode: result=0, result_hi=0, ILL=1.
- Z = (result==0). N = result[WIDTH-1]. Both are valid for all legal ops.
- DIV/MOD, B!=0: state goes IDLE->DIV; busy=1 for exactly WIDTH cycles (one quotient bit per cycle, MSB first, restoring). Then DONE with res_valid=1, for a total latency of WIDTH+1 edges after accept.
  - DIV: result = quotient, result_hi = remainder.
  - MOD: result = remainder, result_hi = quotient.
  - C=0.
- DIV/MOD, B==0: no iteration; latency 1. result = all ones (DIV) or A (MOD); result_hi = the other one; DZ=1.
- Handshake out: result, result_hi and flags stay stable while res_valid && !res_ready. On res_valid && res_ready, res_valid drops at the next edge and op_ready rises in the same cycle.
- Back-to-back throughput is one op per 2 cycles for single-cycle ops.
- Flags are recomputed per operation; they are not sticky.
- State machine:
  - IDLE -> (accept, DIV/MOD, B!=0) DIV.
  - IDLE -> (accept, other) DONE.
  - DIV -> (count==WIDTH-1) DONE.
  - DONE -> (res_ready) IDLE.
- op_valid while !op_ready is ignored; the requester must hold it.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_XOR).
  - Flag bit indices (FLG_C=0, FLG_Z=1, FLG_N=2, FLG_DZ=3, FLG_ILL=4).
  - State encodings (ST_IDLE, ST_DIV, ST_DONE).
- One sub-module: alu_divider (WIDTH-parametrised restoring divider with start/busy/done, quotient, remainder). The top level holds the handshake FSM and the single-cycle datapath.

Test Plan:
- WIDTH=16; ADD 0xFFFF+0x0001 -> res_valid 1 cycle after accept; result 0x0000, C=1, Z=1, N=0.
- SUB 0x0003-0x0005 -> result 0xFFFE, C=1, N=1; MUL 0x1234*0x0100 -> result 0x3400, result_hi 0x0012, C=1.
- DIV 1000/7 -> busy exactly 16 cycles; res_valid at edge 17; result 142, result_hi 6. MOD 1000/7 -> result 6, result_hi 142.
- DIV 0x00AA/0 and MOD 0x00AA/0 -> latency 1; DIV result 0xFFFF, result_hi 0x00AA, DZ=1; MOD result 0x00AA, result_hi 0xFFFF, DZ=1. Opcode 9 -> result 0, ILL=1.
- Backpressure: hold res_ready=0 for 5 cycles after an XOR 0xF0F0^0x0FF0 -> result 0xFF00 stable, op_ready=0, and a new op_valid is ignored; raise res_ready -> op_ready=1 the next cycle.
- Assert reset at DIV iteration cycle 8 -> next edge: busy=0, res_valid=0, op_ready=1, outputs 0. A following ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the handshake ALU engine.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;

  localparam int unsigned FLG_C   = 0;
  localparam int unsigned FLG_Z   = 1;
  localparam int unsigned FLG_N   = 2;
  localparam int unsigned FLG_DZ  = 3;
  localparam int unsigned FLG_ILL = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_engine_if.sv
// Request/response bundle of the ALU engine; master drives requests, slave is the engine.
interface alu_engine_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
);
  logic             op_valid;
  logic             op_ready;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic [4:0]       flags;
  logic             busy;

  modport master (
    output op_valid, opcode, opa, opb, res_ready,
    input  op_ready, res_valid, result, result_hi, flags, busy
  );

  modport slave (
    input  op_valid, opcode, opa, opb, res_ready,
    output op_ready, res_valid, result, result_hi, flags, busy
  );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles.
module alu_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Partial remainder is always below the divisor, so the trial difference fits WIDTH bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    trial   = shifted[WIDTH-1:0] - dvs_q;
  end

  // Quotient/remainder after the current step; final while done is high.
  assign quotient  = {quo_q[WIDTH-2:0], fits};
  assign remainder = fits ? trial : shifted[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      dvs_q  <= divisor;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quotient;
      rem_q <= remainder;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_engine.sv
// Handshake ALU engine: single-cycle datapath plus result-holding FSM around a divider.
module alu_engine
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 4
) (
  input logic         clock,
  input logic         reset,
  alu_engine_if.slave bus
);
  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [4:0]       flags_q, flags_d, flags_calc;
  logic             mod_q, mod_d;

  logic             accept, b_zero, is_divmod, div_start;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   r_calc, rh_calc;
  logic               c_calc, dz_calc, ill_calc;

  assign bus.op_ready  = (state_q == ST_IDLE) && !bus.res_valid;
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.flags     = flags_q;
  assign bus.busy      = div_busy;

  assign accept    = bus.op_valid && bus.op_ready;
  assign b_zero    = (bus.opb == '0);
  assign is_divmod = (bus.opcode == OPW'(OP_DIV)) || (bus.opcode == OPW'(OP_MOD));
  assign div_start = accept && is_divmod && !b_zero;

  alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (bus.opa),
    .divisor  (bus.opb),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    sum      = {1'b0, bus.opa} + {1'b0, bus.opb};
    diff     = {1'b0, bus.opa} - {1'b0, bus.opb};
    prod     = {{WIDTH{1'b0}}, bus.opa} * {{WIDTH{1'b0}}, bus.opb};
    r_calc   = '0;
    rh_calc  = '0;
    c_calc   = 1'b0;
    dz_calc  = 1'b0;
    ill_calc = 1'b0;
    case (bus.opcode)
      OPW'(OP_ADD): begin r_calc = sum[WIDTH-1:0]; c_calc = sum[WIDTH]; end
      OPW'(OP_SUB): begin r_calc = diff[WIDTH-1:0]; c_calc = diff[WIDTH]; end
      OPW'(OP_MUL): begin
        r_calc  = prod[WIDTH-1:0];
        rh_calc = prod[2*WIDTH-1:WIDTH];
        c_calc  = (prod[2*WIDTH-1:WIDTH] != '0);
      end
      // Only the divide-by-zero outcome is produced here; B!=0 goes through the divider.
      OPW'(OP_DIV): if (b_zero) begin r_calc = '1; rh_calc = bus.opa; dz_calc = 1'b1; end
      OPW'(OP_MOD): if (b_zero) begin r_calc = bus.opa; rh_calc = '1; dz_calc = 1'b1; end
      OPW'(OP_AND): r_calc = bus.opa & bus.opb;
      OPW'(OP_OR):  r_calc = bus.opa | bus.opb;
      OPW'(OP_XOR): r_calc = bus.opa ^ bus.opb;
      default:      ill_calc = 1'b1;
    endcase
    flags_calc          = '0;
    flags_calc[FLG_C]   = c_calc;
    flags_calc[FLG_Z]   = !ill_calc && (r_calc == '0);
    flags_calc[FLG_N]   = !ill_calc && r_calc[WIDTH-1];
    flags_calc[FLG_DZ]  = dz_calc;
    flags_calc[FLG_ILL] = ill_calc;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    mod_d       = mod_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          result_d    = r_calc;
          result_hi_d = rh_calc;
          flags_d     = flags_calc;
          mod_d       = (bus.opcode == OPW'(OP_MOD));
          state_d     = div_start ? ST_DIV : ST_DONE;
        end
      end
      ST_DIV: begin
        if (div_done) begin
          result_d        = mod_q ? div_rem : div_quo;
          result_hi_d     = mod_q ? div_quo : div_rem;
          flags_d         = '0;
          flags_d[FLG_Z]  = (result_d == '0);
          flags_d[FLG_N]  = result_d[WIDTH-1];
          state_d         = ST_DONE;
        end
      end
      ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      mod_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      mod_q       <= mod_d;
    end
  end
endmodule
